fpmult_es_pipe: RTL

- Pipelined, parametrised exponent/sign stage for the FP multiplier datapath.
- Takes operand exponents and signs. Produces:
  - biased product exponent, signed and widened;
  - product sign;
  - exponent classification flags: overflow, underflow, zero, special.
- Carries a valid/ready handshake so it can sit between the operand-unpack stage and the mantissa-normalise stage with backpressure.
- Keeps a saturating overflow-event counter for debug/perf readout.

---
 rtl/fpmult_es_pipe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fpmult_es_pipe.sv
// fpmult_es_pipe: exponent/sign stage of the FP multiplier datapath.
// Forms the biased product exponent, product sign and exponent class flags,
// then carries them through LATENCY register stages with valid/ready flow
// control. A saturating counter tracks how many overflow results retired.
module fpmult_es_pipe #(
  parameter int EXP_W   = 5,
  parameter int BIAS    = 15,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXP_W-1:0]   ea,
  input  logic [EXP_W-1:0]   eb,
  input  logic               sa,
  input  logic               sb,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W+1:0]   ep,
  output logic               sp,
  output logic               ovf,
  output logic               unf,
  output logic               zero,
  output logic               special,
  output logic [CNT_W-1:0]   ovf_cnt
);

  // Product exponent is two bits wider than the field: one bit for the carry
  // of the sum, one for the sign after the bias is removed.
  localparam int EPW = EXP_W + 2;
  // Payload layout: {ep, sp, ovf, unf, zero, special}.
  localparam int PW  = EPW + 5;

  localparam logic signed [EPW-1:0] BIAS_S = EPW'(BIAS);
  localparam logic signed [EPW-1:0] OVF_TH = EPW'((1 << EXP_W) - 1);

  // A depth outside 1..3 is not a supported configuration.
  if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
    $error("fpmult_es_pipe: LATENCY must be in 1..3");
  end

  // ---------------------------------------------------------------------
  // Stage-0 arithmetic (combinational, feeds the first register stage)
  // ---------------------------------------------------------------------
  logic signed [EPW-1:0] ep_s0;
  logic                  sp_s0;
  logic                  ovf_s0;
  logic                  unf_s0;
  logic                  zero_s0;
  logic                  special_s0;
  logic [PW-1:0]         pay_s0;

  // Zero-extended operands cannot wrap at EPW bits, so the signed result
  // covers the whole -BIAS .. 2*(2^EXP_W-1)-BIAS range exactly.
  assign ep_s0      = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
  assign sp_s0      = sa ^ sb;
  assign ovf_s0     = (ep_s0 >= OVF_TH);
  assign unf_s0     = ep_s0[EPW-1] | (ep_s0 == '0);
  // Zero and special are reported independently; the normaliser decides
  // what an Inf*0 or NaN*0 combination means.
  assign zero_s0    = (ea == '0) | (eb == '0);
  assign special_s0 = (&ea) | (&eb);
  assign pay_s0     = {ep_s0, sp_s0, ovf_s0, unf_s0, zero_s0, special_s0};

  // ---------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------
  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] valid_d;
  logic [PW-1:0]      pay_q [LATENCY];
  logic [PW-1:0]      pay_d [LATENCY];
  logic               adv;

  // The whole pipe moves together; bubbles are not squeezed out, so the
  // stall decision only looks at the last stage.
  assign adv      = ~valid_q[LATENCY-1] | out_ready;
  assign in_ready = adv;

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign valid_d[gi] = adv ? in_valid : valid_q[gi];
      assign pay_d[gi]   = adv ? pay_s0   : pay_q[gi];
    end else begin : g_body
      assign valid_d[gi] = adv ? valid_q[gi-1] : valid_q[gi];
      assign pay_d[gi]   = adv ? pay_q[gi-1]   : pay_q[gi];
    end
  end

  // Valid bits are reset so a reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload needs no reset: it is only ever observed behind a valid bit.
  always_ff @(posedge clk) begin
    pay_q <= pay_d;
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  logic [PW-1:0] pay_out;

  assign out_valid = valid_q[LATENCY-1];
  // Gate the payload so the outputs read 0 whenever nothing is valid,
  // including straight after reset when the payload is still unknown.
  assign pay_out   = out_valid ? pay_q[LATENCY-1] : '0;
  assign ep        = pay_out[PW-1:5];
  assign sp        = pay_out[4];
  assign ovf       = pay_out[3];
  assign unf       = pay_out[2];
  assign zero      = pay_out[1];
  assign special   = pay_out[0];

  // ---------------------------------------------------------------------
  // Saturating overflow-event counter
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count only retiring results, so a stalled result is counted once.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && ovf && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ovf_cnt = cnt_q;

endmodule
